// File: rtl/crc32_dat48_frame_engine.sv
// Frame-level CRC-32 engine (poly 0x04C11DB7, MSB-first) over 48-bit words with byte-serial tail.
// Optional expected-CRC compare enabled by defining CRC32_CHECK_EN.
module crc32_dat48_frame_engine #(
    parameter logic [31:0] INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT = 32'h00000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        IN_SOF,
    input  logic        IN_EOF,
    input  logic [2:0]  IN_BYTES,
    input  logic [47:0] IN_DATA,
    output logic        CRC_VALID,
    output logic [31:0] CRC_OUT,
    output logic        FRAME_ERR
`ifdef CRC32_CHECK_EN
    ,
    input  logic [31:0] EXP_CRC,
    output logic        CRC_ERR
`endif
);

    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    // Handshake: a word transfers on a rising edge where IN_VALID and IN_READY are both high;
    // upstream keeps IN_* stable while IN_VALID=1 and IN_READY=0.

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [47:0] hold_q, hold_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] out_q, out_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
`ifdef CRC32_CHECK_EN
    logic [31:0] exp_q, exp_d;
    logic        cerr_q, cerr_d;
`endif

    logic        xfer;
    logic [31:0] crc_in;
    logic [31:0] full_next;
    logic [31:0] byte_next;
    logic [2:0]  nbytes;

    function automatic logic [31:0] crc_word48(input logic [31:0] c, input logic [47:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 47; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ POLY;
        end
        return r;
    endfunction

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ POLY;
        end
        return r;
    endfunction

    assign IN_READY  = (state_q != ST_TAIL) && !RST;
    assign xfer      = IN_VALID && IN_READY;
    assign crc_in    = IN_SOF ? INIT : crc_q;
    assign full_next = crc_word48(crc_in, IN_DATA);
    assign byte_next = crc_byte(crc_q, hold_q[47:40]);
    assign nbytes    = (IN_BYTES == 3'd0 || IN_BYTES == 3'd7) ? 3'd6 : IN_BYTES;

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef CRC32_CHECK_EN
        exp_d   = exp_q;
        cerr_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (xfer) begin
                    if (state_q == ST_IDLE && !IN_SOF) begin
                        ferr_d = 1'b1;
                    end else begin
                        // SOF inside an open frame abandons it and restarts from INIT.
                        if (state_q == ST_RUN && IN_SOF) ferr_d = 1'b1;
                        if (!IN_EOF) begin
                            crc_d   = full_next;
                            state_d = ST_RUN;
                        end else begin
`ifdef CRC32_CHECK_EN
                            exp_d = EXP_CRC;
`endif
                            if (nbytes == 3'd6) begin
                                out_d   = full_next ^ XOROUT;
                                valid_d = 1'b1;
`ifdef CRC32_CHECK_EN
                                cerr_d  = (full_next ^ XOROUT) != EXP_CRC;
`endif
                                crc_d   = INIT;
                                state_d = ST_IDLE;
                            end else begin
                                hold_d  = IN_DATA;
                                cnt_d   = nbytes;
                                crc_d   = crc_in;
                                state_d = ST_TAIL;
                            end
                        end
                    end
                end
            end
            ST_TAIL: begin
                hold_d = {hold_q[39:0], 8'h00};
                cnt_d  = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    out_d   = byte_next ^ XOROUT;
                    valid_d = 1'b1;
`ifdef CRC32_CHECK_EN
                    cerr_d  = (byte_next ^ XOROUT) != exp_q;
`endif
                    crc_d   = INIT;
                    state_d = ST_IDLE;
                end else begin
                    crc_d = byte_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            crc_q   <= INIT;
            hold_q  <= 48'h0;
            cnt_q   <= 3'd0;
            out_q   <= 32'h0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef CRC32_CHECK_EN
            exp_q   <= 32'h0;
            cerr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef CRC32_CHECK_EN
            exp_q   <= exp_d;
            cerr_q  <= cerr_d;
`endif
        end
    end

    assign CRC_VALID = valid_q;
    assign CRC_OUT   = out_q;
    assign FRAME_ERR = ferr_q;
`ifdef CRC32_CHECK_EN
    assign CRC_ERR   = cerr_q;
`endif

endmodule

// File: tb/tb_crc32_dat48_frame_engine.sv
// Randomized bench for crc32_dat48_frame_engine against a byte-stream CRC-32/MPEG-2 model.
// Define CRC32_CHECK_EN to also exercise the expected-CRC compare.
module tb_crc32_dat48_frame_engine;

    localparam logic [31:0] POLY   = 32'h04C11DB7;
    localparam logic [31:0] INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] XOROUT = 32'h00000000;
    localparam logic [31:0] STD_CRC = 32'h0376E6E7;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic        IN_SOF = 1'b0;
    logic        IN_EOF = 1'b0;
    logic [2:0]  IN_BYTES = 3'd0;
    logic [47:0] IN_DATA = 48'h0;
    logic        CRC_VALID;
    logic [31:0] CRC_OUT;
    logic        FRAME_ERR;
`ifdef CRC32_CHECK_EN
    logic [31:0] EXP_CRC = 32'h0;
    logic        CRC_ERR;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_xfer = 0;

    logic [31:0] got_crc_q[$];
    int          got_cyc_q[$];
    logic        got_cerr_q[$];
    int          err_cyc_q[$];
    int          stray_cerr = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  msg_q[$];

    crc32_dat48_frame_engine dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_SOF    (IN_SOF),
        .IN_EOF    (IN_EOF),
        .IN_BYTES  (IN_BYTES),
        .IN_DATA   (IN_DATA),
        .CRC_VALID (CRC_VALID),
        .CRC_OUT   (CRC_OUT),
        .FRAME_ERR (FRAME_ERR)
`ifdef CRC32_CHECK_EN
        ,
        .EXP_CRC   (EXP_CRC),
        .CRC_ERR   (CRC_ERR)
`endif
    );

    // ---------------- clock / cycle counter / monitor ----------------
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (CRC_VALID === 1'b1) begin
            got_crc_q.push_back(CRC_OUT);
            got_cyc_q.push_back(cyc);
`ifdef CRC32_CHECK_EN
            got_cerr_q.push_back(CRC_ERR);
`else
            got_cerr_q.push_back(1'b0);
`endif
        end
`ifdef CRC32_CHECK_EN
        if (CRC_ERR === 1'b1 && CRC_VALID !== 1'b1) stray_cerr++;
`endif
        if (FRAME_ERR === 1'b1) err_cyc_q.push_back(cyc);
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    // ---------------- reference model: byte-serial CRC over msg_q ----------------
    function automatic logic [31:0] model_crc();
        logic [31:0] c;
        c = INIT;
        foreach (msg_q[i]) begin
            c = c ^ {msg_q[i], 24'h0};
            for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c ^ XOROUT;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic sof, input logic eof, input logic [2:0] nb,
                             input logic [47:0] d);
        int n;
        IN_VALID = 1'b1;
        IN_SOF   = sof;
        IN_EOF   = eof;
        IN_BYTES = nb;
        IN_DATA  = d;
        n = 0;
        while (IN_READY !== 1'b1 && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL send_ready_timeout waited=%0d required<40", n);
        end
        last_xfer = cyc;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        IN_SOF   = 1'b0;
        IN_EOF   = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic wait_results(input int count, input int budget, output logic ok);
        int n;
        n = 0;
        while (got_crc_q.size() < count && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        ok = (got_crc_q.size() >= count);
    endtask

    task automatic flush();
        got_crc_q.delete();
        got_cyc_q.delete();
        got_cerr_q.delete();
        err_cyc_q.delete();
        exp_q.delete();
        msg_q.delete();
    endtask

    task automatic send_std();
        send_word(1'b1, 1'b0, 3'd6, 48'h313233343536);
        send_word(1'b0, 1'b1, 3'd3, 48'h373839A5C35A);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1;
        idle_cycles(3);
        checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", IN_READY); end
        checks++; if (CRC_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", CRC_VALID); end
        checks++; if (CRC_OUT !== 32'h0) begin errors++; $display("FAIL reset_crc_out got=%h exp=0", CRC_OUT); end
        checks++; if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", FRAME_ERR); end
        RST = 1'b0;
        idle_cycles(1);
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", IN_READY); end
    endtask

    task automatic test_std_vector();
        int e;
        logic ok;
        flush();
        send_std();
        e = last_xfer;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (IN_READY !== (k == 4)) begin
                errors++;
                $display("FAIL tail_ready cycle+%0d got=%b exp=%b", k, IN_READY, (k == 4));
            end
            if (k < 4) idle_cycles(1);
        end
        wait_results(1, 10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL std_no_result got=0 results exp=1");
        end else begin
            checks++; if (got_cyc_q[0] - e != 4) begin errors++; $display("FAIL std_latency got=%0d exp=4", got_cyc_q[0] - e); end
            checks++; if (got_crc_q[0] !== STD_CRC) begin errors++; $display("FAIL std_crc got=%h exp=%h", got_crc_q[0], STD_CRC); end
        end
        idle_cycles(4);
        checks++; if (got_crc_q.size() != 1) begin errors++; $display("FAIL std_extra_results got=%0d exp=1", got_crc_q.size()); end
        checks++; if (err_cyc_q.size() != 0) begin errors++; $display("FAIL std_frame_err got=%0d exp=0", err_cyc_q.size()); end
    endtask

    task automatic test_back_to_back();
        int e;
        logic ok;
        flush();
        send_std();
        e = last_xfer;
        send_word(1'b1, 1'b0, 3'd6, 48'h313233343536);
        checks++; if (last_xfer - e != 4) begin errors++; $display("FAIL b2b_accept_cycle got=%0d exp=4", last_xfer - e); end
        send_word(1'b0, 1'b1, 3'd3, 48'h3738390F0F0F);
        wait_results(2, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_results got=%0d exp=2", got_crc_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_crc_q[i] !== STD_CRC) begin errors++; $display("FAIL b2b_crc%0d got=%h exp=%h", i, got_crc_q[i], STD_CRC); end
            end
        end
    endtask

    task automatic test_single_word();
        logic [2:0]  nbs[3];
        logic [31:0] exp;
        logic        ok;
        int          e;
        nbs[0] = 3'd6; nbs[1] = 3'd0; nbs[2] = 3'd7;
        for (int t = 0; t < 3; t++) begin
            flush();
            for (int i = 0; i < 6; i++) msg_q.push_back(8'h00);
            exp = model_crc();
            send_word(1'b1, 1'b1, nbs[t], 48'h0);
            e = last_xfer;
            wait_results(1, 10, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL single_no_result bytes=%0d", nbs[t]);
            end else begin
                checks++; if (got_cyc_q[0] - e != 1) begin errors++; $display("FAIL single_latency bytes=%0d got=%0d exp=1", nbs[t], got_cyc_q[0] - e); end
                checks++; if (got_crc_q[0] !== exp) begin errors++; $display("FAIL single_crc bytes=%0d got=%h exp=%h", nbs[t], got_crc_q[0], exp); end
            end
        end
    endtask

    task automatic test_no_sof();
        int   e;
        logic ok;
        logic [31:0] r;
        flush();
        r = $urandom;
        send_word(1'b0, 1'b0, 3'd6, {r, 16'h1234});
        e = last_xfer;
        idle_cycles(6);
        checks++;
        if (err_cyc_q.size() != 1) begin
            errors++;
            $display("FAIL nosof_err_count got=%0d exp=1", err_cyc_q.size());
        end else begin
            checks++; if (err_cyc_q[0] - e != 1) begin errors++; $display("FAIL nosof_err_cycle got=%0d exp=1", err_cyc_q[0] - e); end
        end
        checks++; if (got_crc_q.size() != 0) begin errors++; $display("FAIL nosof_valid got=%0d exp=0", got_crc_q.size()); end
        send_std();
        wait_results(1, 10, ok);
        checks++;
        if (!ok || got_crc_q[0] !== STD_CRC) begin
            errors++;
            $display("FAIL nosof_followup_crc got=%h exp=%h", ok ? got_crc_q[0] : 32'hx, STD_CRC);
        end
    endtask

    task automatic test_restart();
        logic [47:0] b;
        logic [31:0] r1, r2, exp;
        logic ok;
        int e;
        flush();
        r1 = $urandom; r2 = $urandom;
        b = {r1, r2[15:0]};
        for (int i = 0; i < 6; i++) msg_q.push_back(b[47 - 8*i -: 8]);
        exp = model_crc();
        send_word(1'b1, 1'b0, 3'd6, 48'hDEADBEEFCAFE);
        send_word(1'b1, 1'b1, 3'd6, b);
        e = last_xfer;
        wait_results(1, 10, ok);
        idle_cycles(2);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL restart_no_result");
        end else begin
            checks++; if (got_crc_q[0] !== exp) begin errors++; $display("FAIL restart_crc got=%h exp=%h", got_crc_q[0], exp); end
            checks++;
            if (err_cyc_q.size() != 1 || err_cyc_q[0] != got_cyc_q[0] || got_cyc_q[0] - e != 1) begin
                errors++;
                $display("FAIL restart_err_coincide errs=%0d got_valid_cyc=%0d exp=%0d", err_cyc_q.size(), got_cyc_q[0], e + 1);
            end
        end
    endtask

    task automatic test_reset_in_tail();
        logic ok;
        flush();
        send_std();
        RST = 1'b1;
        #1;
        checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL rst_tail_ready got=%b exp=0", IN_READY); end
        @(posedge CLK); #1;
        RST = 1'b0;
        idle_cycles(8);
        checks++; if (got_crc_q.size() != 0) begin errors++; $display("FAIL rst_tail_valid got=%0d exp=0", got_crc_q.size()); end
        checks++; if (CRC_OUT !== 32'h0) begin errors++; $display("FAIL rst_tail_crc_out got=%h exp=0", CRC_OUT); end
        send_std();
        wait_results(1, 10, ok);
        checks++;
        if (!ok || got_crc_q[0] !== STD_CRC) begin
            errors++;
            $display("FAIL rst_tail_followup_crc got=%h exp=%h", ok ? got_crc_q[0] : 32'hx, STD_CRC);
        end
    endtask

    task automatic test_random();
        int nframes, nw, nb_eff, gap;
        logic [2:0]  nbf;
        logic [31:0] r1, r2;
        logic [47:0] d;
        logic        ok;
        flush();
        nframes = 24;
        for (int f = 0; f < nframes; f++) begin
            msg_q.delete();
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                r1 = $urandom; r2 = $urandom;
                d = {r1, r2[15:0]};
                nbf = 3'($urandom_range(0, 7));
                nb_eff = (w == nw - 1) ? ((nbf == 0 || nbf == 7) ? 6 : int'(nbf)) : 6;
                for (int i = 0; i < nb_eff; i++) msg_q.push_back(d[47 - 8*i -: 8]);
                send_word(w == 0, w == nw - 1, nbf, d);
                gap = $urandom_range(0, 2);
                if (gap > 0) idle_cycles(gap);
            end
            exp_q.push_back(model_crc());
        end
        wait_results(nframes, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL random_result_count got=%0d exp=%0d", got_crc_q.size(), nframes);
        end
        while (got_crc_q.size() > 0 && exp_q.size() > 0) begin
            logic [31:0] g, x;
            g = got_crc_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (g !== x) begin errors++; $display("FAIL random_crc got=%h exp=%h", g, x); end
        end
        checks++; if (err_cyc_q.size() != 0) begin errors++; $display("FAIL random_frame_err got=%0d exp=0", err_cyc_q.size()); end
    endtask

`ifdef CRC32_CHECK_EN
    task automatic test_check_en();
        logic [31:0] exps[2];
        logic ok;
        exps[0] = 32'h0376E6E7;
        exps[1] = 32'h0376E6E6;
        for (int t = 0; t < 2; t++) begin
            flush();
            EXP_CRC = exps[t];
            send_std();
            wait_results(1, 10, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL check_no_result exp_crc=%h", exps[t]);
            end else begin
                checks++;
                if (got_cerr_q[0] !== (t == 1)) begin
                    errors++;
                    $display("FAIL check_crc_err exp_crc=%h got=%b exp=%b", exps[t], got_cerr_q[0], (t == 1));
                end
            end
        end
        idle_cycles(3);
        checks++; if (stray_cerr != 0) begin errors++; $display("FAIL check_stray_crc_err got=%0d exp=0", stray_cerr); end
    endtask
`endif

    initial begin
        test_reset();
        test_std_vector();
        test_back_to_back();
        test_single_word();
        test_no_sof();
        test_restart();
        test_reset_in_tail();
        test_random();
`ifdef CRC32_CHECK_EN
        test_check_en();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
